// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg
// Shared definitions for the two-port data-memory arbiter.
// Holds the arbiter state encoding and the port count and memory
// geometry constants used by the arbiter and its round-robin picker.
package dmem_arbiter_pkg;

  localparam int NUM_PORTS  = 2;
  localparam int DMEM_IDX_W = 8;
  localparam int DMEM_DEPTH = 256;

  // IDLE  : waiting for a request, grant decided combinationally
  // ISSUE : captured request driven onto the memory bus for one cycle
  // RESP  : completion pulse back to the granted port
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2
// Two-way round-robin picker.
// Ports:
//   valid[1:0] : request pending per port
//   ptr        : preferred port when both are pending
//   grant[1:0] : one-hot winner (all zero when nothing is pending)
module rr_arb2
  import dmem_arbiter_pkg::*;
(
  input  logic [NUM_PORTS-1:0] valid,
  input  logic                 ptr,
  output logic [NUM_PORTS-1:0] grant
);

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Arbitrates a core load/store port (0) and a DMA/debug port (1) onto a
// single 256-word data memory with at most one transaction in flight.
// Ports:
//   clk, reset_n                 : clock, asynchronous active-low reset
//   req_valid/req_ready[1:0]     : per-port request handshake
//   req_we[1:0]                  : per-port write enable (0 = read)
//   req_addr0/1, req_wdata0/1    : per-port word address and write data
//   rsp_valid[1:0]               : one-cycle completion pulse per port
//   rsp_err, rsp_rdata           : completion status and read data
//   address, writeData           : memory address and write data
//   memRead, memWrite            : memory strobes
//   ReadData                     : registered memory read data
module dmem_arbiter
  import dmem_arbiter_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NUM_PORTS-1:0] req_valid,
  output logic [NUM_PORTS-1:0] req_ready,
  input  logic [NUM_PORTS-1:0] req_we,
  input  logic [63:0]          req_addr0,
  input  logic [63:0]          req_addr1,
  input  logic [63:0]          req_wdata0,
  input  logic [63:0]          req_wdata1,
  output logic [NUM_PORTS-1:0] rsp_valid,
  output logic                 rsp_err,
  output logic [63:0]          rsp_rdata,
  output logic [63:0]          address,
  output logic [63:0]          writeData,
  output logic                 memRead,
  output logic                 memWrite,
  input  logic [63:0]          ReadData
);

  arb_state_t           state;
  arb_state_t           next_state;
  logic                 rr_ptr;
  logic                 cap_we;
  logic                 cap_port;
  logic                 cap_err;
  logic [63:0]          cap_addr;
  logic [63:0]          cap_wdata;

  logic [NUM_PORTS-1:0] grant;
  logic                 sel_port;
  logic                 sel_we;
  logic                 sel_err;
  logic [63:0]          sel_addr;
  logic [63:0]          sel_wdata;
  logic                 accept;

  rr_arb2 u_rr_arb2 (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  assign sel_port  = grant[1];
  assign sel_we    = sel_port ? req_we[1]  : req_we[0];
  assign sel_addr  = sel_port ? req_addr1  : req_addr0;
  assign sel_wdata = sel_port ? req_wdata1 : req_wdata0;
  // Anything above the 256-word window is rejected without touching memory.
  assign sel_err   = |sel_addr[63:DMEM_IDX_W];
  assign accept    = (state == IDLE) && (|req_valid);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      cap_we    <= 1'b0;
      cap_port  <= 1'b0;
      cap_err   <= 1'b0;
      cap_addr  <= 64'd0;
      cap_wdata <= 64'd0;
    end else begin
      state <= next_state;
      if (accept) begin
        cap_we    <= sel_we;
        cap_port  <= sel_port;
        cap_err   <= sel_err;
        cap_addr  <= sel_addr;
        cap_wdata <= sel_wdata;
        // The loser of this round is preferred next time.
        rr_ptr    <= ~sel_port;
      end
    end
  end

  always_comb begin
    next_state = state;
    req_ready  = '0;
    rsp_valid  = '0;
    rsp_err    = 1'b0;
    rsp_rdata  = 64'd0;
    address    = 64'd0;
    writeData  = 64'd0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    case (state)
      IDLE: begin
        // reset_n gates the combinational grant so every output is
        // quiet while reset is held, even with requests pending.
        if (reset_n && (|req_valid)) begin
          req_ready  = grant;
          next_state = sel_err ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        address    = cap_addr;
        writeData  = cap_wdata;
        memWrite   = cap_we;
        memRead    = ~cap_we;
        next_state = RESP;
      end
      RESP: begin
        rsp_valid  = cap_port ? 2'b10 : 2'b01;
        rsp_err    = cap_err;
        rsp_rdata  = (cap_we || cap_err) ? 64'd0 : ReadData;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge clk.
REQ-002 reset_n  input  1  asynchronous, active-low reset.
REQ-003 req_valid[1:0]  input  2  request pending, one bit per port (0 = core load/store, 1 = DMA/debug).
REQ-004 req_ready[1:0]  output  2  request accepted this cycle, per port.
REQ-005 req_we[1:0]  input  2  1 = write, 0 = read, per port.
REQ-006 req_addr0, req_addr1  input  64 each  byte-agnostic word address; bits [7:0] index the 256-word data memory.
REQ-007 req_wdata0, req_wdata1  input  64 each  write data.
REQ-008 rsp_valid[1:0]  output  2  one-cycle completion pulse, per port.
REQ-009 rsp_err  output  1  completion is an out-of-range error; valid only with rsp_valid.
REQ-010 rsp_rdata  output  64  read data; valid only with rsp_valid.
REQ-011 address, writeData  output  64 each  to data memory.
REQ-012 memRead, memWrite  output  1 each  to data memory.
REQ-013 ReadData  input  64  from data memory; registered, valid the cycle after memRead is sampled.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, RESP; at most one transaction is outstanding.
REQ-015 In IDLE with any req_valid set, the arbiter SHALL combinationally assert req_ready for exactly one winner, capture its we/addr/wdata and port id, and leave IDLE at the next edge.
REQ-016 Arbitration SHALL be round-robin: rr_ptr names the preferred port; if only one port is valid it wins; after each grant rr_ptr SHALL point to the non-granted port.
REQ-017 req_ready SHALL be 0 in ISSUE and RESP; requesters hold valid and payload until ready.
REQ-018 If captured addr[63:8] != 0, IDLE SHALL go directly to RESP with no memory access; otherwise IDLE SHALL go to ISSUE.
REQ-019 In ISSUE, address/writeData SHALL be driven from captured registers, with memWrite = we and memRead = !we, for exactly one cycle.
REQ-020 memRead and memWrite SHALL never be high simultaneously and SHALL be 0 outside ISSUE; address and writeData SHALL be 0 outside ISSUE.
REQ-021 In RESP, rsp_valid SHALL pulse for the granted port only; rsp_rdata = ReadData for reads, 0 for writes and errors; rsp_err = 1 only for out-of-range requests; RESP SHALL then always return to IDLE.
REQ-022 Latency: accept edge -> RESP two cycles later for in-range requests, one cycle later for errors; peak throughput is one in-range transaction per 3 cycles.
REQ-023 A new request SHALL be grantable in the IDLE cycle immediately following RESP.
REQ-024 There is no response back-pressure; requesters SHALL sample rsp_valid every cycle.

Reset
REQ-025 Asserting reset_n low SHALL asynchronously force state=IDLE, rr_ptr=0, and all captured registers to 0, making every output 0; reset mid-transaction SHALL abandon it without rsp_valid.
REQ-026 After deassertion, the first grant SHALL follow rr_ptr=0, so port 0 wins a simultaneous request.

Structure
REQ-027 A shared package SHALL hold the state enum (IDLE, ISSUE, RESP), NUM_PORTS=2, DMEM_IDX_W=8, and DMEM_DEPTH=256.
REQ-028 Round-robin selection SHALL live in one sub-module, rr_arb2 (inputs: valid[1:0], ptr; output: one-hot grant[1:0]).

Verification
REQ-029 Port 0 write addr=0x10, wdata=0xDEADBEEF_CAFEF00D; then port 0 read 0x10 -> memWrite pulses one cycle, then the read rsp_rdata = 0xDEADBEEF_CAFEF00D, rsp_err=0.
REQ-030 Both ports valid from reset -> grants in order 0,1,0,1; each rsp_valid appears on the granted port 2 cycles after its accept.
REQ-031 Port 1 read addr=0x100 -> no memRead/memWrite; rsp_valid[1] one cycle after accept, rsp_err=1, rsp_rdata=0.
REQ-032 Port 0 held valid continuously with port 1 idle -> accepted every 3 cycles; req_ready is never high in ISSUE or RESP.
REQ-033 reset_n driven low during ISSUE -> outputs 0 immediately, no rsp_valid; after release, a simultaneous request grants port 0.
REQ-034 Assertion check for every test: memRead & memWrite is never 1, and rsp_valid is at most one-hot.
